// File: rtl/inst_decode_stage.sv
// Registered opcode/func one-hot decoder with two-entry skid buffer.
// Sits between fetch and control/execute; counts accepted illegal ops.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   flush          : sync flush, drops both entries and the current input
//   in_valid/ready : upstream handshake; in_ready is purely registered
//   opcode, func   : instruction fields (OPC_W each)
//   in_pc          : PC travelling with the instruction
//   out_valid/ready: downstream handshake
//   out_inst       : one-hot decode, bit 0 leftmost, zero when illegal
//   out_idx        : merged decode index
//   out_pc         : PC of the output entry
//   out_illegal    : index is not legal in LEGAL_MASK
//   illegal_cnt    : saturating count of accepted illegal instructions
module inst_decode_stage #(
  parameter int                  OPC_W      = 6,
  parameter int                  PC_W       = 32,
  parameter logic [2**OPC_W-1:0] LEGAL_MASK = '1,
  parameter int                  CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [OPC_W-1:0]   func,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:2**OPC_W-1] out_inst,
  output logic [OPC_W-1:0]   out_idx,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int N = 2**OPC_W;

  typedef struct packed {
    logic [0:N-1]     inst;
    logic [OPC_W-1:0] idx;
    logic [PC_W-1:0]  pc;
    logic             ill;
  } ent_t;

  ent_t             m_q, s_q, d;
  logic             m_v, s_v;
  logic             acc, rel;
  logic [OPC_W-1:0] idx;
  logic [CNT_W-1:0] cnt_q;

  // func only merges in when the opcode MSB is clear
  assign idx = opcode | (func & {OPC_W{~opcode[OPC_W-1]}});

  always_comb begin
    d         = '0;
    d.idx     = idx;
    d.pc      = in_pc;
    d.ill     = ~LEGAL_MASK[idx];
    d.inst[idx] = LEGAL_MASK[idx];
  end

  assign in_ready = ~s_v;
  assign acc      = in_valid & in_ready & ~flush;
  assign rel      = m_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (rel && s_v) begin
      // skid drains first; in_ready is low so no accept this cycle
      m_q <= s_q;
      s_v <= 1'b0;
    end else if (acc && (!m_v || rel)) begin
      m_q <= d;
      m_v <= 1'b1;
    end else if (acc) begin
      s_q <= d;
      s_v <= 1'b1;
    end else if (rel) begin
      m_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (acc && d.ill && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = m_v;
  assign out_inst    = m_q.inst;
  assign out_idx     = m_q.idx;
  assign out_pc      = m_q.pc;
  assign out_illegal = m_q.ill;
  assign illegal_cnt = cnt_q;

endmodule
